cla_word_seq: RTL

Nibble-serial multi-word adder sequencer wrapped around a 4-bit registered carry-lookahead slice. It accepts two WORDS×4-bit operands as a stream of nibble pairs, LSB first. It adds them one nibble per cycle, chaining the slice's registered carry-out into the next nibble. It then streams the sum back out LSB first, with a final carry. This is the stage that extends the 4-bit CLA to wide operands on the pin-limited top level.

---
 rtl/cla_seq_pkg.sv | 12 +
 rtl/cla4_slice.sv | 47 ++++
 rtl/cla_word_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA word sequencer.
package cla_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        LOAD,
        ADD,
        OUT
    } cla_seq_state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice with registered sum and carry-out.
module cla4_slice
    import cla_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_ci,
    output logic [NIBBLE_W-1:0] o_s,
    output logic                o_co
);

    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W:0]   w_c;
    logic [NIBBLE_W-1:0] r_s;
    logic                r_co;

    assign w_g = i_a & i_b;
    assign w_p = i_a | i_b;

    // Flattened lookahead: every carry comes straight from g/p and ci.
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= '0;
            r_co <= 1'b0;
        end else if (i_en) begin
            r_s  <= i_a ^ i_b ^ w_c[NIBBLE_W-1:0];
            r_co <= w_c[NIBBLE_W];
        end
    end

    assign o_s  = r_s;
    assign o_co = r_co;

endmodule

// File: rtl/cla_word_seq.sv
// Nibble-serial WORDS x 4-bit adder: load LSB-first, add through cla4_slice, stream sum out.
// Define CLA_SEQ_OVF_EN to add the signed-overflow output out_ovf.
module cla_word_seq
    import cla_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] in_a,
    input  logic [NIBBLE_W-1:0] in_b,
    input  logic                in_ci,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NIBBLE_W-1:0] out_sum,
    output logic                out_last,
`ifdef CLA_SEQ_OVF_EN
    output logic                out_ovf,
`endif
    output logic                out_co
);

    localparam int unsigned   IW        = $clog2(WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(WORDS - 1);
    localparam logic [IW-1:0] FINAL_IDX = IW'(WORDS);

    cla_seq_state_t      r_state, w_state_d;
    logic [IW-1:0]       r_idx, w_idx_d, w_idx_m1;
    logic [NIBBLE_W-1:0] r_a   [WORDS];
    logic [NIBBLE_W-1:0] r_b   [WORDS];
    logic [NIBBLE_W-1:0] r_sum [WORDS];
    logic                r_ci;
    logic                r_co;
`ifdef CLA_SEQ_OVF_EN
    logic                r_ovf;
`endif

    logic                w_in_hs, w_out_hs;
    logic [NIBBLE_W-1:0] w_a_nib, w_b_nib, w_sum_nib;
    logic                w_slice_en, w_slice_ci, w_slice_co;
    logic [NIBBLE_W-1:0] w_slice_s;

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;
    assign w_idx_m1 = r_idx - IW'(1);

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        unique case (r_state)
            LOAD: begin
                if (w_in_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_d   = '0;
                        w_state_d = ADD;
                    end else begin
                        w_idx_d = r_idx + IW'(1);
                    end
                end
            end
            ADD: begin
                if (r_idx == FINAL_IDX) begin
                    w_idx_d   = '0;
                    w_state_d = OUT;
                end else begin
                    w_idx_d = r_idx + IW'(1);
                end
            end
            OUT: begin
                if (w_out_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_d   = '0;
                        w_state_d = LOAD;
                    end else begin
                        w_idx_d = r_idx + IW'(1);
                    end
                end
            end
            default: begin
                w_idx_d   = '0;
                w_state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
        end
    end

    // Index muxes; idx == WORDS in the last ADD cycle selects nothing.
    always_comb begin
        w_a_nib   = '0;
        w_b_nib   = '0;
        w_sum_nib = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (IW'(i) == r_idx) begin
                w_a_nib   = r_a[i];
                w_b_nib   = r_b[i];
                w_sum_nib = r_sum[i];
            end
        end
    end

    assign w_slice_en = (r_state == ADD) && (r_idx != FINAL_IDX);
    assign w_slice_ci = (r_idx == '0) ? r_ci : w_slice_co;

    cla4_slice u_slice (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_slice_en),
        .i_a   (w_a_nib),
        .i_b   (w_b_nib),
        .i_ci  (w_slice_ci),
        .o_s   (w_slice_s),
        .o_co  (w_slice_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_sum[i] <= '0;
            end
            r_ci <= 1'b0;
            r_co <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            r_ovf <= 1'b0;
`endif
        end else begin
            if (r_state == LOAD && w_in_hs) begin
                for (int i = 0; i < int'(WORDS); i++) begin
                    if (IW'(i) == r_idx) begin
                        r_a[i] <= in_a;
                        r_b[i] <= in_b;
                    end
                end
                if (r_idx == '0) r_ci <= in_ci;
            end
            // Slice output lags its inputs by one cycle, hence idx-1.
            if (r_state == ADD && r_idx != '0) begin
                for (int i = 0; i < int'(WORDS); i++) begin
                    if (IW'(i) == w_idx_m1) r_sum[i] <= w_slice_s;
                end
            end
            if (r_state == ADD && r_idx == FINAL_IDX) begin
                r_co <= w_slice_co;
`ifdef CLA_SEQ_OVF_EN
                r_ovf <= (r_a[WORDS-1][NIBBLE_W-1] == r_b[WORDS-1][NIBBLE_W-1])
                      && (w_slice_s[NIBBLE_W-1] != r_a[WORDS-1][NIBBLE_W-1]);
`endif
            end
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == OUT);
    assign out_sum   = out_valid ? w_sum_nib : '0;
    assign out_last  = out_valid && (r_idx == LAST_IDX);
    assign out_co    = out_last && r_co;
`ifdef CLA_SEQ_OVF_EN
    assign out_ovf   = out_last && r_ovf;
`endif

endmodule
